// File: rtl/fifo_sp_384x32_ctrl_if.sv
`default_nettype none
// ============================================================================
// fifo_sp_384x32_ctrl_if : push/pop stream and SRAM initiator signal bundle
// Revision: 1.0
// ============================================================================
interface fifo_sp_384x32_ctrl_if #(
  parameter int ADR_WD = 9,
  parameter int DAT_WD = 32
);
  logic              push_val_i;
  logic [DAT_WD-1:0] push_dat_i;
  logic              push_rdy_o;
  logic              pop_val_o;
  logic [DAT_WD-1:0] pop_dat_o;
  logic              pop_rdy_i;
  logic [ADR_WD:0]   cnt_o;
  logic [ADR_WD-1:0] adr_o;
  logic              wr_ena_o;
  logic [DAT_WD-1:0] wr_dat_o;
  logic              rd_ena_o;
  logic [DAT_WD-1:0] rd_dat_i;

  // Controller side
  modport slave (
    input  push_val_i, push_dat_i, pop_rdy_i, rd_dat_i,
    output push_rdy_o, pop_val_o, pop_dat_o, cnt_o,
    output adr_o, wr_ena_o, wr_dat_o, rd_ena_o
  );

  // Pipeline / SRAM side
  modport master (
    output push_val_i, push_dat_i, pop_rdy_i, rd_dat_i,
    input  push_rdy_o, pop_val_o, pop_dat_o, cnt_o,
    input  adr_o, wr_ena_o, wr_dat_o, rd_ena_o
  );
endinterface
`default_nettype wire

// File: rtl/fifo_sp_384x32_ctrl.sv
`default_nettype none
// ============================================================================
// fifo_sp_384x32_ctrl : FIFO controller over a single-port 384x32 SRAM
// Revision: 1.0
// ============================================================================
module fifo_sp_384x32_ctrl #(
  parameter int ADR_WD = 9,
  parameter int DAT_WD = 32,
  parameter int DEPTH  = 384
) (
  input  wire logic               clk,
  input  wire logic               rst,
  fifo_sp_384x32_ctrl_if.slave    bus
);
  localparam int                CW         = ADR_WD + 1;
  localparam logic [ADR_WD-1:0] c_last_adr = ADR_WD'(DEPTH - 1);
  localparam logic [CW-1:0]     c_depth    = CW'(DEPTH);

  logic              r_in_vld;
  logic [DAT_WD-1:0] r_in_dat;
  logic [ADR_WD-1:0] r_wptr;
  logic [ADR_WD-1:0] r_rptr;
  logic [CW-1:0]     r_ram_cnt;
  logic              r_rd_inflight;
  logic [1:0]        r_out_cnt;
  logic [DAT_WD-1:0] r_out_dat0;
  logic [DAT_WD-1:0] r_out_dat1;

  logic w_rd_req;
  logic w_wr_gnt;
  logic w_push_rdy;
  logic w_pop_val;
  logic w_push_hs;
  logic w_pop_hs;

  // Reads win arbitration so the output buffer refills before deferred writes
  assign w_rd_req   = (r_ram_cnt != '0) &&
                      (({1'b0, r_out_cnt} + {2'b00, r_rd_inflight}) < 3'd2);
  assign w_wr_gnt   = r_in_vld && !w_rd_req && (r_ram_cnt != c_depth);
  assign w_push_rdy = !r_in_vld || w_wr_gnt;
  assign w_pop_val  = (r_out_cnt != 2'd0);
  assign w_push_hs  = bus.push_val_i && w_push_rdy;
  assign w_pop_hs   = w_pop_val && bus.pop_rdy_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_vld <= 1'b0;
    end else if (w_push_hs) begin
      r_in_vld <= 1'b1;
    end else if (w_wr_gnt) begin
      r_in_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_hs) begin
      r_in_dat <= bus.push_dat_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_ram_cnt     <= '0;
      r_rd_inflight <= 1'b0;
    end else begin
      if (w_wr_gnt) begin
        r_wptr <= (r_wptr == c_last_adr) ? '0 : r_wptr + 1'b1;
      end
      if (w_rd_req) begin
        r_rptr <= (r_rptr == c_last_adr) ? '0 : r_rptr + 1'b1;
      end
      if (w_wr_gnt) begin
        r_ram_cnt <= r_ram_cnt + 1'b1;
      end else if (w_rd_req) begin
        r_ram_cnt <= r_ram_cnt - 1'b1;
      end
      r_rd_inflight <= w_rd_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_cnt <= 2'd0;
    end else begin
      case ({r_rd_inflight, w_pop_hs})
        2'b10:   r_out_cnt <= r_out_cnt + 2'd1;
        2'b01:   r_out_cnt <= r_out_cnt - 2'd1;
        default: r_out_cnt <= r_out_cnt;
      endcase
    end
  end

  // Entry 0 is the head; returning read data lands right behind the survivors
  always_ff @(posedge clk) begin
    if (r_rd_inflight) begin
      if (w_pop_hs) begin
        if (r_out_cnt == 2'd2) begin
          r_out_dat0 <= r_out_dat1;
          r_out_dat1 <= bus.rd_dat_i;
        end else begin
          r_out_dat0 <= bus.rd_dat_i;
        end
      end else if (r_out_cnt == 2'd0) begin
        r_out_dat0 <= bus.rd_dat_i;
      end else begin
        r_out_dat1 <= bus.rd_dat_i;
      end
    end else if (w_pop_hs) begin
      r_out_dat0 <= r_out_dat1;
    end
  end

  assign bus.push_rdy_o = w_push_rdy;
  assign bus.pop_val_o  = w_pop_val;
  assign bus.pop_dat_o  = r_out_dat0;
  assign bus.cnt_o      = CW'(r_in_vld) + r_ram_cnt + CW'(r_rd_inflight) + CW'(r_out_cnt);
  assign bus.adr_o      = w_wr_gnt ? r_wptr : r_rptr;
  assign bus.wr_ena_o   = w_wr_gnt;
  assign bus.wr_dat_o   = r_in_dat;
  assign bus.rd_ena_o   = w_rd_req;
endmodule
`default_nettype wire

// File: tb/tb_fifo_sp_384x32_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fifo_sp_384x32_ctrl : directed bench with SRAM model and order scoreboard
// Revision: 1.0
// ============================================================================
module tb_fifo_sp_384x32_ctrl;
  logic clk;
  logic rst;

  fifo_sp_384x32_ctrl_if #(.ADR_WD(9), .DAT_WD(32)) bus ();

  fifo_sp_384x32_ctrl #(.ADR_WD(9), .DAT_WD(32), .DEPTH(384)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk   = 0;
  int n_fail  = 0;
  int n_pop   = 0;
  int n_coll  = 0;
  int n_unst  = 0;
  int n_wwrap = 0;
  int n_rwrap = 0;
  int adr_max = 0;
  logic [31:0] mem [0:511];
  logic [31:0] sb_q [$];
  logic        hold_prev = 1'b0;
  logic [31:0] hold_dat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port SRAM with one-cycle read latency
  always @(posedge clk) begin
    if (bus.wr_ena_o) mem[bus.adr_o] <= bus.wr_dat_o;
    if (bus.rd_ena_o) bus.rd_dat_i <= mem[bus.adr_o];
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Run-wide monitors: bus collisions, address range, wraps, hold stability, ordering
  always @(negedge clk) begin
    if (bus.rd_ena_o && bus.wr_ena_o) n_coll++;
    if ((bus.rd_ena_o || bus.wr_ena_o) && int'(bus.adr_o) > adr_max) adr_max = int'(bus.adr_o);
    if (bus.wr_ena_o && bus.adr_o == 9'd383) n_wwrap++;
    if (bus.rd_ena_o && bus.adr_o == 9'd383) n_rwrap++;
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && (!bus.pop_val_o || bus.pop_dat_o != hold_dat)) n_unst++;
      hold_prev = bus.pop_val_o && !bus.pop_rdy_i;
      hold_dat  = bus.pop_dat_o;
      if (bus.push_val_i && bus.push_rdy_o) sb_q.push_back(bus.push_dat_i);
      if (bus.pop_val_o && bus.pop_rdy_i) begin
        n_pop++;
        if (sb_q.size() == 0) chk("pop_underflow", 1, 0);
        else chk("pop_order", bus.pop_dat_o, sb_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.push_val_i = 1'b0;
    bus.pop_rdy_i  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    sb_q.delete();
  endtask

  task automatic push_word(input logic [31:0] dat);
    logic hs;
    logic done;
    done = 1'b0;
    bus.push_val_i = 1'b1;
    bus.push_dat_i = dat;
    for (int c = 0; c < 50 && !done; c++) begin
      hs = bus.push_rdy_o;
      tick();
      if (hs) done = 1'b1;
    end
    bus.push_val_i = 1'b0;
    if (!done) chk("push_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   acc;
    int   sent;
    int   p0;
    int   w0;
    int   r0;
    logic hs;
    logic done;
    rst = 1'b1;
    bus.push_val_i = 1'b0;
    bus.push_dat_i = '0;
    bus.pop_rdy_i  = 1'b0;

    // Reset values and empty-FIFO latency
    do_reset();
    chk("rst_push_rdy", bus.push_rdy_o, 1);
    chk("rst_pop_val", bus.pop_val_o, 0);
    chk("rst_cnt", bus.cnt_o, 0);
    chk("rst_wr_ena", bus.wr_ena_o, 0);
    chk("rst_rd_ena", bus.rd_ena_o, 0);
    chk("rst_adr", bus.adr_o, 0);
    bus.push_val_i = 1'b1;
    bus.push_dat_i = 32'hA5A5_0001;
    tick();
    bus.push_val_i = 1'b0;
    chk("t1_n1_wr_ena", bus.wr_ena_o, 1);
    chk("t1_n1_adr", bus.adr_o, 0);
    chk("t1_n1_cnt", bus.cnt_o, 1);
    tick();
    chk("t1_n2_rd_ena", bus.rd_ena_o, 1);
    chk("t1_n2_wr_ena", bus.wr_ena_o, 0);
    chk("t1_n2_adr", bus.adr_o, 0);
    chk("t1_n2_cnt", bus.cnt_o, 1);
    tick();
    chk("t1_n3_pop_val", bus.pop_val_o, 0);
    chk("t1_n3_cnt", bus.cnt_o, 1);
    tick();
    chk("t1_n4_pop_val", bus.pop_val_o, 1);
    chk("t1_n4_pop_dat", bus.pop_dat_o, 32'hA5A5_0001);
    chk("t1_n4_cnt", bus.cnt_o, 1);
    bus.pop_rdy_i = 1'b1;
    tick();
    bus.pop_rdy_i = 1'b0;
    chk("t1_after_pop_cnt", bus.cnt_o, 0);
    chk("t1_after_pop_val", bus.pop_val_o, 0);

    // Fill to maximum occupancy, then drain in order
    do_reset();
    acc = 0;
    bus.push_val_i = 1'b1;
    bus.push_dat_i = 32'd0;
    for (int c = 0; c < 600; c++) begin
      hs = bus.push_rdy_o;
      tick();
      if (hs) begin
        acc++;
        bus.push_dat_i = acc;
      end
    end
    bus.push_val_i = 1'b0;
    chk("t2_accepted", acc, 387);
    chk("t2_full_push_rdy", bus.push_rdy_o, 0);
    chk("t2_full_cnt", bus.cnt_o, 387);
    p0 = n_pop;
    bus.pop_rdy_i = 1'b1;
    for (int c = 0; c < 1500 && bus.cnt_o != 0; c++) tick();
    bus.pop_rdy_i = 1'b0;
    chk("t2_drain_cnt", bus.cnt_o, 0);
    chk("t2_drain_pops", n_pop - p0, 387);

    // Long random-gap stream across pointer wrap
    do_reset();
    sent = 0;
    p0 = n_pop;
    w0 = n_wwrap;
    r0 = n_rwrap;
    done = 1'b0;
    for (int c = 0; c < 20000 && !done; c++) begin
      bus.push_val_i = (sent < 1000) && ($urandom_range(0, 3) != 0);
      bus.push_dat_i = 32'h1000_0000 + sent;
      bus.pop_rdy_i  = ($urandom_range(0, 2) != 0);
      hs = bus.push_val_i && bus.push_rdy_o;
      tick();
      if (hs) sent++;
      if (sent == 1000 && bus.cnt_o == 0) done = 1'b1;
    end
    bus.push_val_i = 1'b0;
    bus.pop_rdy_i  = 1'b0;
    chk("t3_sent", sent, 1000);
    chk("t3_pops", n_pop - p0, 1000);
    chk("t3_cnt_zero", bus.cnt_o, 0);
    chk("t3_wr_wraps_ge2", (n_wwrap - w0) >= 2, 1);
    chk("t3_rd_wraps_ge2", (n_rwrap - r0) >= 2, 1);

    // Read priority while the output buffer refills
    do_reset();
    for (int i = 0; i < 12; i++) push_word(32'h4000_0000 + i);
    repeat (8) tick();
    chk("t4_pre_cnt", bus.cnt_o, 12);
    chk("t4_pre_head", bus.pop_dat_o, 32'h4000_0000);
    bus.pop_rdy_i  = 1'b1;
    bus.push_val_i = 1'b1;
    bus.push_dat_i = 32'h4000_000C;
    tick();
    bus.push_val_i = 1'b0;
    chk("t4_a1_rd_ena", bus.rd_ena_o, 1);
    chk("t4_a1_wr_ena", bus.wr_ena_o, 0);
    chk("t4_a1_adr", bus.adr_o, 2);
    tick();
    bus.pop_rdy_i = 1'b0;
    chk("t4_a2_rd_ena", bus.rd_ena_o, 1);
    chk("t4_a2_wr_ena", bus.wr_ena_o, 0);
    chk("t4_a2_adr", bus.adr_o, 3);
    chk("t4_a2_push_rdy", bus.push_rdy_o, 0);
    tick();
    chk("t4_a3_wr_ena", bus.wr_ena_o, 1);
    chk("t4_a3_rd_ena", bus.rd_ena_o, 0);
    chk("t4_a3_adr", bus.adr_o, 12);
    bus.pop_rdy_i = 1'b1;
    for (int c = 0; c < 200 && bus.cnt_o != 0; c++) tick();
    bus.pop_rdy_i = 1'b0;
    chk("t4_drain_cnt", bus.cnt_o, 0);

    // Reset while a read is in flight
    do_reset();
    push_word(32'hDEAD_0005);
    tick();
    chk("t5_rd_pre", bus.rd_ena_o, 1);
    rst = 1'b1;
    tick();
    chk("t5_pop_val", bus.pop_val_o, 0);
    chk("t5_cnt", bus.cnt_o, 0);
    chk("t5_push_rdy", bus.push_rdy_o, 1);
    rst = 1'b0;
    sb_q.delete();
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t5_post_pop_val", bus.pop_val_o, 0);
      chk("t5_post_cnt", bus.cnt_o, 0);
    end
    bus.pop_rdy_i = 1'b1;
    push_word(32'h0000_0055);
    for (int c = 0; c < 20 && !bus.pop_val_o; c++) tick();
    chk("t5_next_val", bus.pop_val_o, 1);
    chk("t5_next_dat", bus.pop_dat_o, 32'h0000_0055);
    tick();
    bus.pop_rdy_i = 1'b0;
    chk("t5_next_cnt", bus.cnt_o, 0);

    // Toggling consumer backpressure
    do_reset();
    p0 = n_pop;
    for (int i = 0; i < 20; i++) push_word(32'h6000_0000 + i);
    sent = 0;
    done = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      bus.pop_rdy_i  = ~bus.pop_rdy_i;
      bus.push_val_i = (sent < 20);
      bus.push_dat_i = 32'h6000_0014 + sent;
      hs = bus.push_val_i && bus.push_rdy_o;
      tick();
      if (hs) sent++;
      if (sent == 20 && bus.cnt_o == 0) done = 1'b1;
    end
    bus.push_val_i = 1'b0;
    bus.pop_rdy_i  = 1'b0;
    chk("t6_pops", n_pop - p0, 40);
    chk("t6_sb_empty", sb_q.size(), 0);

    // Run-wide properties
    chk("no_rd_wr_collision", n_coll, 0);
    chk("pop_dat_stable", n_unst, 0);
    chk("adr_in_range", adr_max <= 383, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
